// File: rtl/cpu_scoreboard.sv
// cpu_scoreboard: per-register pending-write counters that gate instruction issue.
// Define CPU_SCOREBOARD_FPU_EN to also track the FP register bank (IDs 32-63).
module cpu_scoreboard #(
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_issue_valid,
    input  logic [5:0]           i_issue_rs1,
    input  logic [5:0]           i_issue_rs2,
    input  logic [5:0]           i_issue_rs3,
    input  logic                 i_issue_rs3_used,
    input  logic [5:0]           i_issue_rd,
    input  logic                 i_issue_rd_wr,
    output logic                 o_issue_ready,
    input  logic [TAG_WIDTH-1:0] i_retire_tag,
    input  logic [5:0]           i_retire_rd,
    input  logic                 i_flush,
    output logic [63:0]          o_pending,
    output logic [15:0]          o_stall_cycles
);

`ifdef CPU_SCOREBOARD_FPU_EN
    localparam int unsigned IDX_W = 6;
`else
    localparam int unsigned IDX_W = 5;
`endif
    localparam int unsigned NREG = 1 << IDX_W;

    typedef logic [IDX_W-1:0] idx_t;

    logic [NREG-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]           last_tag_q;
    logic [63:0]                    pending_q, pending_d;
    logic [15:0]                    stall_q, stall_d;

    idx_t rs1_idx, rs2_idx, rs3_idx, rd_idx, ret_idx;
    logic rs1_busy, rs2_busy, rs3_busy, rd_full;
    logic issue_fire, retire_evt, retire_fire;

    // x0 is hardwired; without the FPU option the whole FP bank is invisible.
    function automatic logic tracked(input logic [5:0] id);
`ifdef CPU_SCOREBOARD_FPU_EN
        return id != 6'd0;
`else
        return !id[5] && (id[4:0] != 5'd0);
`endif
    endfunction

    assign rs1_idx = i_issue_rs1[IDX_W-1:0];
    assign rs2_idx = i_issue_rs2[IDX_W-1:0];
    assign rs3_idx = i_issue_rs3[IDX_W-1:0];
    assign rd_idx  = i_issue_rd[IDX_W-1:0];
    assign ret_idx = i_retire_rd[IDX_W-1:0];

    // Readiness looks only at registered counters: a same-cycle retire is not bypassed.
    always_comb begin
        rs1_busy = tracked(i_issue_rs1) && (cnt_q[rs1_idx] != '0);
        rs2_busy = tracked(i_issue_rs2) && (cnt_q[rs2_idx] != '0);
        rs3_busy = i_issue_rs3_used && tracked(i_issue_rs3) && (cnt_q[rs3_idx] != '0);
        rd_full  = i_issue_rd_wr && tracked(i_issue_rd) && (cnt_q[rd_idx] == '1);
        o_issue_ready = !i_reset && !(rs1_busy || rs2_busy || rs3_busy || rd_full);
    end

    assign issue_fire  = i_issue_valid && o_issue_ready && i_issue_rd_wr && tracked(i_issue_rd);
    assign retire_evt  = (i_retire_tag != last_tag_q);
    assign retire_fire = retire_evt && tracked(i_retire_rd) && (cnt_q[ret_idx] != '0);

    // Issue and retire to the same register cancel; otherwise each applies on its own.
    always_comb begin
        cnt_d = cnt_q;
        if (i_flush) begin
            cnt_d = '0;
        end else begin
            if (issue_fire && !(retire_fire && (ret_idx == rd_idx))) begin
                cnt_d[rd_idx] = cnt_q[rd_idx] + CNT_WIDTH'(1);
            end
            if (retire_fire && !(issue_fire && (ret_idx == rd_idx))) begin
                cnt_d[ret_idx] = cnt_q[ret_idx] - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        pending_d = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            pending_d[r] = |cnt_d[r];
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (i_issue_valid && !o_issue_ready && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q      <= '0;
            last_tag_q <= '0;
            pending_q  <= '0;
            stall_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_tag_q <= i_retire_tag;
            pending_q  <= pending_d;
            stall_q    <= stall_d;
        end
    end

    assign o_pending      = pending_q;
    assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed, table-driven bench for cpu_scoreboard (default build: FP bank untracked).
module tb_cpu_scoreboard;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_issue_valid = 1'b0;
    logic [5:0]  i_issue_rs1 = '0;
    logic [5:0]  i_issue_rs2 = '0;
    logic [5:0]  i_issue_rs3 = '0;
    logic        i_issue_rs3_used = 1'b0;
    logic [5:0]  i_issue_rd = '0;
    logic        i_issue_rd_wr = 1'b0;
    logic        o_issue_ready;
    logic [3:0]  i_retire_tag = '0;
    logic [5:0]  i_retire_rd = '0;
    logic        i_flush = 1'b0;
    logic [63:0] o_pending;
    logic [15:0] o_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_scoreboard #(.TAG_WIDTH(4), .CNT_WIDTH(2)) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_issue_valid    (i_issue_valid),
        .i_issue_rs1      (i_issue_rs1),
        .i_issue_rs2      (i_issue_rs2),
        .i_issue_rs3      (i_issue_rs3),
        .i_issue_rs3_used (i_issue_rs3_used),
        .i_issue_rd       (i_issue_rd),
        .i_issue_rd_wr    (i_issue_rd_wr),
        .o_issue_ready    (o_issue_ready),
        .i_retire_tag     (i_retire_tag),
        .i_retire_rd      (i_retire_rd),
        .i_flush          (i_flush),
        .o_pending        (o_pending),
        .o_stall_cycles   (o_stall_cycles)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        valid;
        logic [5:0]  rs1, rs2, rs3;
        logic        rs3_used;
        logic [5:0]  rd;
        logic        rd_wr;
        logic [3:0]  tag;
        logic [5:0]  ret_rd;
        logic        flush;
        logic        exp_ready;
        logic [63:0] exp_pend;
        logic [15:0] exp_stall;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [5:0] r1, input logic [5:0] r2,
                                input logic [5:0] r3, input logic u3, input logic [5:0] rd,
                                input logic wr, input logic [3:0] tag, input logic [5:0] ret,
                                input logic fl, input logic er, input logic [63:0] ep,
                                input logic [15:0] es);
        vec_t x;
        x.valid = v; x.rs1 = r1; x.rs2 = r2; x.rs3 = r3; x.rs3_used = u3;
        x.rd = rd; x.rd_wr = wr; x.tag = tag; x.ret_rd = ret; x.flush = fl;
        x.exp_ready = er; x.exp_pend = ep; x.exp_stall = es;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_issue_valid    = v.valid;
        i_issue_rs1      = v.rs1;
        i_issue_rs2      = v.rs2;
        i_issue_rs3      = v.rs3;
        i_issue_rs3_used = v.rs3_used;
        i_issue_rd       = v.rd;
        i_issue_rd_wr    = v.rd_wr;
        i_retire_tag     = v.tag;
        i_retire_rd      = v.ret_rd;
        i_flush          = v.flush;
    endtask

    // Drive at the falling edge, check ready before the rising edge, state just after it.
    task automatic run_vec(input string name, input vec_t v);
        @(negedge i_clock);
        drive(v);
        #1;
        check({name, "_ready"}, 64'(o_issue_ready), 64'(v.exp_ready));
        @(posedge i_clock);
        #1;
        check({name, "_pend"}, o_pending, v.exp_pend);
        check({name, "_stall"}, 64'(o_stall_cycles), 64'(v.exp_stall));
    endtask

    task automatic cycle(input vec_t v);
        @(negedge i_clock);
        drive(v);
        @(posedge i_clock);
        #1;
    endtask

    vec_t tbl[31];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,      0, 0,     0, 1, 64'h0,    0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 5, 1,      0, 0,     0, 1, 64'h20,   0);
        tbl[2]  = mk(1, 5, 0, 0, 0, 0, 0,      0, 0,     0, 0, 64'h20,   1);
        tbl[3]  = mk(1, 5, 0, 0, 0, 0, 0,      1, 5,     0, 0, 64'h0,    2);
        tbl[4]  = mk(1, 5, 0, 0, 0, 0, 0,      1, 5,     0, 1, 64'h0,    2);
        tbl[5]  = mk(1, 0, 0, 0, 0, 7, 1,      1, 0,     0, 1, 64'h80,   2);
        tbl[6]  = mk(1, 0, 0, 0, 0, 7, 1,      1, 0,     0, 1, 64'h80,   2);
        tbl[7]  = mk(1, 0, 0, 0, 0, 7, 1,      1, 0,     0, 1, 64'h80,   2);
        tbl[8]  = mk(1, 0, 0, 0, 0, 7, 1,      1, 0,     0, 0, 64'h80,   3);
        tbl[9]  = mk(1, 0, 0, 0, 0, 7, 1,      2, 7,     0, 0, 64'h80,   4);
        tbl[10] = mk(1, 0, 0, 0, 0, 7, 1,      2, 7,     0, 1, 64'h80,   4);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,      3, 7,     0, 1, 64'h80,   4);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,      4, 7,     0, 1, 64'h80,   4);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,      5, 7,     0, 1, 64'h0,    4);
        tbl[14] = mk(1, 0, 0, 0, 0, 9, 1,      5, 0,     0, 1, 64'h200,  4);
        tbl[15] = mk(1, 0, 0, 0, 0, 9, 1,      6, 9,     0, 1, 64'h200,  4);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,      7, 9,     0, 1, 64'h0,    4);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,      8, 9,     0, 1, 64'h0,    4);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 1,      8, 0,     0, 1, 64'h0,    4);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 1,      9, 0,     0, 1, 64'h0,    4);
        tbl[20] = mk(1, 0, 0, 0, 0, 6'h21, 1,  9, 0,     0, 1, 64'h0,    4);
        tbl[21] = mk(1, 6'h21, 0, 0, 0, 0, 0,  9, 0,     0, 1, 64'h0,    4);
        tbl[22] = mk(1, 0, 0, 0, 0, 12, 1,     9, 0,     0, 1, 64'h1000, 4);
        tbl[23] = mk(1, 0, 12, 0, 0, 0, 0,     9, 0,     0, 0, 64'h1000, 5);
        tbl[24] = mk(1, 0, 0, 12, 0, 0, 0,     9, 0,     0, 1, 64'h1000, 5);
        tbl[25] = mk(1, 0, 0, 12, 1, 0, 0,     9, 0,     0, 0, 64'h1000, 6);
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,      10, 12,   0, 1, 64'h0,    6);
        tbl[27] = mk(1, 0, 0, 0, 0, 13, 1,     10, 0,    0, 1, 64'h2000, 6);
        tbl[28] = mk(1, 0, 0, 0, 0, 14, 1,     11, 13,   0, 1, 64'h4000, 6);
        tbl[29] = mk(0, 0, 0, 0, 0, 0, 0,      12, 14,   0, 1, 64'h0,    6);
        tbl[30] = mk(0, 0, 0, 0, 0, 0, 0,      13, 6'h21, 0, 1, 64'h0,   6);

        #1 i_reset = 1'b1;
        #1;
        check("reset_pend", o_pending, 64'h0);
        check("reset_stall", 64'(o_stall_cycles), 64'h0);
        check("reset_ready", 64'(o_issue_ready), 64'h0);
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            run_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Held retire tag must count as a single retire event.
        cycle(mk(1, 0, 0, 0, 0, 3, 1, 13, 0, 0, 0, 0, 0));
        cycle(mk(1, 0, 0, 0, 0, 3, 1, 13, 0, 0, 0, 0, 0));
        check("held_pre", o_pending, 64'h8);
        repeat (10) cycle(mk(0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0));
        check("held_tag_once", o_pending, 64'h8);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0));
        check("held_next_evt", o_pending, 64'h0);

        // Flush with concurrent issue; tag is still captured during the flush.
        cycle(mk(1, 0, 0, 0, 0, 3, 1, 4, 0, 0, 0, 0, 0));
        cycle(mk(1, 0, 0, 0, 0, 40, 1, 4, 0, 0, 0, 0, 0));
        check("flush_pre", o_pending, 64'h8);
        run_vec("flush", mk(1, 0, 0, 0, 0, 3, 1, 5, 9, 1, 1, 64'h0, 6));
        cycle(mk(1, 0, 0, 0, 0, 3, 1, 5, 3, 0, 0, 0, 0));
        check("flush_tag_captured", o_pending, 64'h8);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 6, 3, 0, 0, 0, 0));
        check("flush_post_drain", o_pending, 64'h0);

        // Asynchronous reset in the middle of a stall.
        cycle(mk(1, 0, 0, 0, 0, 6, 1, 6, 0, 0, 0, 0, 0));
        cycle(mk(1, 6, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0));
        cycle(mk(1, 6, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0));
        check("stall_pre_reset", 64'(o_stall_cycles), 64'd8);
        check("pend_pre_reset", o_pending, 64'h40);
        @(negedge i_clock);
        #2 i_reset = 1'b1;
        #1;
        check("async_rst_pend", o_pending, 64'h0);
        check("async_rst_stall", 64'(o_stall_cycles), 64'h0);
        check("async_rst_ready", 64'(o_issue_ready), 64'h0);
        i_retire_tag  = 4'd0;
        i_issue_valid = 1'b0;
        @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        i_issue_valid = 1'b1;
        #1;
        check("post_rst_ready_rs6", 64'(o_issue_ready), 64'h1);
        i_issue_rs1 = 6'h21;
        #1;
        check("fp_rs1_ready", 64'(o_issue_ready), 64'h1);
        cycle(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0));
        repeat (2) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0));
        check("post_rst_tag0_no_evt", o_pending, 64'h40);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0));
        check("post_rst_first_evt", o_pending, 64'h0);
        check("post_rst_stall", 64'(o_stall_cycles), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
